mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the shared 64 KiB byte-addressed data/instruction RAM. It lets the instruction-fetch port and the load/store port share one RAM, one transaction per cycle, using a round-robin grant. Sub-word stores become a two-cycle read-modify-write, because the RAM only writes whole 32-bit words. Read data returns registered, one cycle after grant.

## Interface
- ADDR_W, 16, byte-address width; must match the RAM.
- DATA_W, 32, word width; little-endian byte lanes.
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request; held with i_addr until granted.
- i_addr  in  ADDR_W  instruction byte address.
- i_gnt  out  1  one-cycle grant; request is consumed this cycle.
- i_rvalid  out  1  i_rdata valid; one cycle.
- i_rdata  out  DATA_W  read word.
- i_err  out  1  alignment error pulse; tied 0 unless MEM_ARB_ALIGN_CHK_EN.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_be until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data, lane-aligned.
- d_be  in  4  store byte enables; ignored for loads.
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  same meaning as the i_ ports; d_rvalid is for loads only.
- ram_rd_addr  out  ADDR_W  RAM read address (RAM read is combinational).
- ram_rd_data  in  DATA_W  RAM read word.
- ram_wr_en, ram_wr_addr, ram_wr_data  out  1/ADDR_W/DATA_W  RAM write strobe, address and data; RAM writes on the rising edge.

## Operation
- FSM states:
  - IDLE: arbitrate. Grants are combinational: gnt = req & won & state==IDLE.
  - RMW_WR: one cycle; no grants.
- Round-robin pointer `last`:
  - Reset value is INSTR, so the data port wins the first tie.
  - Under continuous contention, grants alternate D, I, D, I.
  - A lone requester is granted every eligible cycle.
- Read grant:
  - ram_rd_addr = request address.
  - ram_rd_data is captured into the port's rdata register.
  - rvalid = 1 in the next cycle.
  - rdata holds its value until that port's next read.
- Store with d_be = 4'hF: ram_wr_en = 1 in the grant cycle, with wr_addr = d_addr and wr_data = d_wdata.
- Store with d_be = 4'h0: granted, no RAM write.
- Other d_be values:
  - Grant cycle: read the old word at d_addr; latch addr, wdata, be and the old word; go to RMW_WR.
  - RMW_WR: write the merged word (lane k from d_wdata if be[k], else the old word), then return to IDLE.
- Addresses are passed through unchanged. Wrap-around at 0xFFFD–0xFFFF is the RAM's modulo behaviour.
- Reset mid-RMW: the pending write is discarded and the state returns to IDLE.

## Timing
- Reset values:
  - state = IDLE, last = INSTR.
  - i/d_rvalid = 0, i/d_rdata = 0, i/d_err = 0.
  - ram_wr_en = 0.
  - Grants are forced to 0 while n_rst is low.
- Read latency: grant at T, rvalid at T+1. Back-to-back reads sustain 1 per cycle.
- Full-word store: done at the edge ending cycle T. A read of the same address granted at T+1 returns the new data.
- Partial store: occupies T and T+1. The next grant is possible at T+2.
- Requests arriving during RMW_WR wait and are arbitrated at T+2, with the pointer already updated to DATA.
- At most one RAM access is issued per cycle, so there is no read/write collision.

## Configuration
- MEM_ARB_ALIGN_CHK_EN defined:
  - Any request with addr[1:0] != 0 is still granted but not executed: no RAM write, and no RMW.
  - Loads and instruction reads return rvalid = 1 with rdata = 0.
  - The port's err pulses in the same cycle as rvalid (stores: cycle after grant).
- Not defined: err outputs are constant 0, and misaligned accesses are executed as byte-addressed.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, RMW_WR};
  - port index enum {INSTR, DATA};
  - BE_FULL = 4'hF;
  - byte-merge function merge_be(old, new, be).
- One sub-module, mem_arb_rr: 2-way round-robin picker. Inputs req[1:0], last; outputs grant one-hot and winner; pointer update is enabled by any grant.

## Test plan
- Reset held low with both req high → no grants, all outputs 0. Release → d_gnt first.
- i_req and d_req (load) both held for 4 cycles → grants D, I, D, I; rvalids follow 1 cycle later with the RAM words.
- Store 0x11223344 to addr 0x0010 with be = F, then load 0x0010 the next cycle → d_rdata = 0x11223344.
- Preload 0xAABBCCDD at 0x0020; store 0x00005500 with be = 4'b0010 → d_gnt, 1 stall cycle, RAM = 0xAABB55DD; i_req during the stall is granted at T+2.
- Store with be = 0 to 0x0030 holding 0x12345678 → granted, word unchanged. Assert n_rst low during RMW_WR → no write occurs.
- With MEM_ARB_ALIGN_CHK_EN: load 0x0041 → d_rvalid = 1, d_rdata = 0, d_err = 1. Store to 0x0042 → RAM unchanged, d_err pulse. Without the macro, the same load returns bytes 0x41–0x44.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
// Optional feature macro: MEM_ARB_ALIGN_CHK_EN (alignment check).
package mem_arb_pkg;

    localparam int WORD_W = 32;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } port_e;

    // Lane k comes from new_w where be[k] is set, else from old_w.
    function automatic logic [WORD_W-1:0] merge_be(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] m;
        m = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; the port that did not win last time
// takes a tie. Bit 0 is the instruction port, bit 1 the data port.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    output logic [1:0] grant,
    output port_e      winner
);

    // Pick the winner and drive a one-hot grant for it.
    always_comb begin
        winner = INSTR;
        unique case (req)
            2'b01:   winner = INSTR;
            2'b10:   winner = DATA;
            2'b11:   winner = (last == INSTR) ? DATA : INSTR;
            default: winner = INSTR;
        endcase
        grant    = 2'b00;
        grant[0] = req[0] & (winner == INSTR);
        grant[1] = req[1] & (winner == DATA);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one word-write RAM between fetch and load/store.
// Optional feature macro: MEM_ARB_ALIGN_CHK_EN (misaligned access -> err).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data
);

    state_e            state;
    port_e             last;
    port_e             winner;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              idle;
    logic              i_mis;
    logic              d_mis;
    logic              d_full;
    logic              d_part;
    logic              d_load;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_wdata;
    logic [DATA_W-1:0] rmw_old;
    logic [3:0]        rmw_be;

    assign idle = (state == IDLE);
    assign req  = {d_req, i_req} & {2{idle & n_rst}};

    mem_arb_rr u_rr (
        .req    (req),
        .last   (last),
        .grant  (grant),
        .winner (winner)
    );

    assign i_gnt = grant[0];
    assign d_gnt = grant[1];

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign i_mis = |i_addr[1:0];
    assign d_mis = |d_addr[1:0];
`else
    assign i_mis = 1'b0;
    assign d_mis = 1'b0;
`endif

    assign d_load = d_gnt & ~d_we;
    assign d_full = d_gnt & d_we & ~d_mis & (d_be == BE_FULL);
    assign d_part = d_gnt & d_we & ~d_mis
                  & (d_be != BE_FULL) & (d_be != 4'h0);

    // Only one RAM access per cycle: the read side serves whichever
    // port won, the write side serves full stores or the RMW tail.
    assign ram_rd_addr = i_gnt ? i_addr : d_addr;
    assign ram_wr_en   = d_full | (state == RMW_WR);
    assign ram_wr_addr = idle ? d_addr : rmw_addr;
    assign ram_wr_data = idle ? d_wdata
                              : merge_be(rmw_old, rmw_wdata, rmw_be);

    // Sequencer state and round-robin pointer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            last  <= INSTR;
        end else begin
            state <= d_part ? RMW_WR : IDLE;
            if (|grant) last <= winner;
        end
    end

    // Capture the partial store and the old word for the merge cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_old   <= '0;
            rmw_be    <= '0;
        end else if (d_part) begin
            rmw_addr  <= d_addr;
            rmw_wdata <= d_wdata;
            rmw_old   <= ram_rd_data;
            rmw_be    <= d_be;
        end
    end

    // Registered read return; rdata holds until the port's next read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_load;
            if (i_gnt) i_rdata <= i_mis ? '0 : ram_rd_data;
            if (d_load) d_rdata <= d_mis ? '0 : ram_rd_data;
        end
    end

`ifdef MEM_ARB_ALIGN_CHK_EN
    // Alignment error pulses one cycle after the offending grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            i_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            i_err <= i_gnt & i_mis;
            d_err <= d_gnt & d_mis;
        end
    end
`else
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed RAM model.
// Expected values are hand-computed constants.
module tb_mem_arbiter;

    logic        clk;
    logic        n_rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        ram_wr_en;
    logic [15:0] ram_wr_addr;
    logic [31:0] ram_wr_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    mem_arbiter dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .i_err       (i_err),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .d_err       (d_err),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational little-endian read, modulo 64 KiB.
    assign ram_rd_data = {mem[16'(ram_rd_addr + 16'd3)],
                          mem[16'(ram_rd_addr + 16'd2)],
                          mem[16'(ram_rd_addr + 16'd1)],
                          mem[ram_rd_addr]};

    // Whole-word write on the rising edge.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr]                  <= ram_wr_data[7:0];
            mem[16'(ram_wr_addr + 16'd1)]     <= ram_wr_data[15:8];
            mem[16'(ram_wr_addr + 16'd2)]     <= ram_wr_data[23:16];
            mem[16'(ram_wr_addr + 16'd3)]     <= ram_wr_data[31:24];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [15:0] a, input logic [31:0] w);
        mem[a]              = w[7:0];
        mem[16'(a + 16'd1)] = w[15:8];
        mem[16'(a + 16'd2)] = w[23:16];
        mem[16'(a + 16'd3)] = w[31:24];
    endtask

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem[16'(a + 16'd3)], mem[16'(a + 16'd2)],
                mem[16'(a + 16'd1)], mem[a]};
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        put_word(16'h0100, 32'h01020304);
        put_word(16'h0200, 32'hA5A55A5A);
        put_word(16'h0020, 32'hAABBCCDD);
        put_word(16'h0030, 32'h12345678);
        for (int i = 0; i < 8; i++) mem[16'h0040 + i] = 8'(8'h40 + i);

        n_rst   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 16'h0100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0200;
        d_wdata = 32'h0;
        d_be    = 4'h0;

        // Reset with both requests pending.
        step();
        step();
        check("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        check("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_wr_en", {31'b0, ram_wr_en}, 32'd0);
        check("rst_err", {30'b0, i_err, d_err}, 32'd0);

        // Contention: D, I, D, I.
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_d_gnt", {31'b0, d_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_i_gnt", {31'b0, i_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            if (k % 2 == 0) begin
                check("rr_d_rvalid", {31'b0, d_rvalid}, 32'd1);
                check("rr_d_rdata", d_rdata, 32'hA5A55A5A);
                check("rr_i_rvalid0", {31'b0, i_rvalid}, 32'd0);
            end else begin
                check("rr_i_rvalid", {31'b0, i_rvalid}, 32'd1);
                check("rr_i_rdata", i_rdata, 32'h01020304);
                check("rr_d_rvalid0", {31'b0, d_rvalid}, 32'd0);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        check("hold_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        check("hold_i_rdata", i_rdata, 32'h01020304);

        // Full-word store then load of the same address.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 32'h11223344;
        d_be    = 4'hF;
        #1;
        check("st_gnt", {31'b0, d_gnt}, 32'd1);
        check("st_wr_en", {31'b0, ram_wr_en}, 32'd1);
        check("st_wr_addr", {16'b0, ram_wr_addr}, 32'h0010);
        step();
        d_we = 1'b0;
        #1;
        check("ld_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("ld_rvalid", {31'b0, d_rvalid}, 32'd1);
        check("ld_rdata", d_rdata, 32'h11223344);

        // Partial store: one stall cycle, then I wins the tie.
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0020;
        d_wdata = 32'h00005500;
        d_be    = 4'b0010;
        #1;
        check("rmw_gnt", {31'b0, d_gnt}, 32'd1);
        check("rmw_wr_en0", {31'b0, ram_wr_en}, 32'd0);
        step();
        d_we   = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0100;
        #1;
        check("rmw_stall_i", {31'b0, i_gnt}, 32'd0);
        check("rmw_stall_d", {31'b0, d_gnt}, 32'd0);
        check("rmw_wr_en", {31'b0, ram_wr_en}, 32'd1);
        check("rmw_wr_addr", {16'b0, ram_wr_addr}, 32'h0020);
        check("rmw_wr_data", ram_wr_data, 32'hAABB55DD);
        step();
        check("rmw_mem", word_at(16'h0020), 32'hAABB55DD);
        check("t2_i_gnt", {31'b0, i_gnt}, 32'd1);
        check("t2_d_gnt", {31'b0, d_gnt}, 32'd0);
        step();
        i_req = 1'b0;
        check("t3_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        #1;
        check("t3_d_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("t3_d_rdata", d_rdata, 32'hAABB55DD);

        // Store with no byte enables: granted, nothing written.
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0030;
        d_wdata = 32'hFFFFFFFF;
        d_be    = 4'h0;
        #1;
        check("be0_gnt", {31'b0, d_gnt}, 32'd1);
        check("be0_wr_en", {31'b0, ram_wr_en}, 32'd0);
        step();
        d_req = 1'b0;
        check("be0_mem", word_at(16'h0030), 32'h12345678);

        // Reset during RMW_WR discards the write.
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_wdata = 32'h000000EE;
        d_be    = 4'b0001;
        step();
        d_req = 1'b0;
        check("rmwr_wr_en", {31'b0, ram_wr_en}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("rmwr_wr_en_rst", {31'b0, ram_wr_en}, 32'd0);
        step();
        check("rmwr_mem", word_at(16'h0030), 32'h12345678);
        n_rst = 1'b1;
        d_req = 1'b1;
        d_we  = 1'b0;
        #1;
        check("rmwr_idle_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("rmwr_ld", d_rdata, 32'h12345678);

        // Misaligned load and store.
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0041;
        #1;
        check("mis_ld_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("mis_ld_rvalid", {31'b0, d_rvalid}, 32'd1);
`ifdef MEM_ARB_ALIGN_CHK_EN
        check("mis_ld_rdata", d_rdata, 32'h0);
        check("mis_ld_err", {31'b0, d_err}, 32'd1);
`else
        check("mis_ld_rdata", d_rdata, 32'h44434241);
        check("mis_ld_err", {31'b0, d_err}, 32'd0);
`endif
        step();
        check("mis_err_clr", {31'b0, d_err}, 32'd0);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0042;
        d_wdata = 32'hDEADBEEF;
        d_be    = 4'hF;
        #1;
        check("mis_st_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
`ifdef MEM_ARB_ALIGN_CHK_EN
        check("mis_st_err", {31'b0, d_err}, 32'd1);
        check("mis_st_mem", word_at(16'h0042), 32'h45444342);
`else
        check("mis_st_err", {31'b0, d_err}, 32'd0);
        check("mis_st_mem", word_at(16'h0042), 32'hDEADBEEF);
`endif
        step();
        check("mis_st_err_clr", {31'b0, d_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
